// File: rtl/axi_color_pkg.sv
// Shared definitions for the colour-stripping AXI address translator:
// attribute widths, counter sizing and the address translation function.
package axi_color_pkg;

  localparam int XLATE_W = 64;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;

  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  // Drop the colour field, shift the bits between it and the bank field down,
  // keep the bank field in place and clear everything else.
  function automatic logic [XLATE_W-1:0] translate_addr(
    input logic [XLATE_W-1:0] addr,
    input int                 color_lsb,
    input int                 color_msb,
    input int                 bank_lsb,
    input int                 bank_w,
    input int                 addr_w
  );
    int                 color_w;
    logic [XLATE_W-1:0] low_mask;
    logic [XLATE_W-1:0] mid_mask;
    logic [XLATE_W-1:0] bank_mask;
    logic [XLATE_W-1:0] addr_mask;
    color_w   = color_msb - color_lsb + 1;
    low_mask  = (XLATE_W'(1) << color_lsb) - XLATE_W'(1);
    mid_mask  = ((XLATE_W'(1) << (bank_lsb - color_w)) - XLATE_W'(1)) & ~low_mask;
    bank_mask = ((XLATE_W'(1) << bank_w) - XLATE_W'(1)) << bank_lsb;
    addr_mask = (XLATE_W'(1) << addr_w) - XLATE_W'(1);
    return ((addr & low_mask) | ((addr >> color_w) & mid_mask) | (addr & bank_mask))
           & addr_mask;
  endfunction

endpackage

// File: rtl/axi_addr_skid.sv
// Two-entry FIFO register slice for an address channel payload.
// The upstream ready is registered so no upstream input reaches it combinationally.
module axi_addr_skid #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PAYLOAD_W-1:0] s_payload,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PAYLOAD_W-1:0] m_payload
);

  logic [PAYLOAD_W-1:0] mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic                 push;
  logic                 pop;

  assign push      = s_valid & s_ready;
  assign pop       = m_valid & m_ready;
  assign m_valid   = (count != 2'd0);
  assign m_payload = mem[rd_ptr];

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count   <= count_next;
      s_ready <= (count_next < 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_payload;
  end

endmodule

// File: rtl/axi_color_translator.sv
// AXI4 address translator: strips colour bits from AW/AR addresses, buffers
// them in skid slices and caps in-flight bursts per direction. W/B/R pass through.
module axi_color_translator
  import axi_color_pkg::*;
#(
  parameter int COLOR_LSB       = 14,
  parameter int COLOR_MSB       = 15,
  parameter int BANK_LSB        = 35,
  parameter int BANK_W          = 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_W            = 16,
  parameter int ADDR_W          = 40,
  parameter int DATA_W          = 128
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_areset,
  // slave side
  input  logic [ID_W-1:0]     s00_axi_awid,
  input  logic [ADDR_W-1:0]   s00_axi_awaddr,
  input  logic [LEN_W-1:0]    s00_axi_awlen,
  input  logic [SIZE_W-1:0]   s00_axi_awsize,
  input  logic [BURST_W-1:0]  s00_axi_awburst,
  input  logic                s00_axi_awlock,
  input  logic [CACHE_W-1:0]  s00_axi_awcache,
  input  logic [PROT_W-1:0]   s00_axi_awprot,
  input  logic [QOS_W-1:0]    s00_axi_awqos,
  input  logic                s00_axi_awvalid,
  output logic                s00_axi_awready,
  input  logic [DATA_W-1:0]   s00_axi_wdata,
  input  logic [DATA_W/8-1:0] s00_axi_wstrb,
  input  logic                s00_axi_wlast,
  input  logic                s00_axi_wvalid,
  output logic                s00_axi_wready,
  output logic [ID_W-1:0]     s00_axi_bid,
  output logic [1:0]          s00_axi_bresp,
  output logic                s00_axi_bvalid,
  input  logic                s00_axi_bready,
  input  logic [ID_W-1:0]     s00_axi_arid,
  input  logic [ADDR_W-1:0]   s00_axi_araddr,
  input  logic [LEN_W-1:0]    s00_axi_arlen,
  input  logic [SIZE_W-1:0]   s00_axi_arsize,
  input  logic [BURST_W-1:0]  s00_axi_arburst,
  input  logic                s00_axi_arlock,
  input  logic [CACHE_W-1:0]  s00_axi_arcache,
  input  logic [PROT_W-1:0]   s00_axi_arprot,
  input  logic [QOS_W-1:0]    s00_axi_arqos,
  input  logic                s00_axi_arvalid,
  output logic                s00_axi_arready,
  output logic [ID_W-1:0]     s00_axi_rid,
  output logic [DATA_W-1:0]   s00_axi_rdata,
  output logic [1:0]          s00_axi_rresp,
  output logic                s00_axi_rlast,
  output logic                s00_axi_rvalid,
  input  logic                s00_axi_rready,
  // master side
  output logic [ID_W-1:0]     m00_axi_awid,
  output logic [ADDR_W-1:0]   m00_axi_awaddr,
  output logic [LEN_W-1:0]    m00_axi_awlen,
  output logic [SIZE_W-1:0]   m00_axi_awsize,
  output logic [BURST_W-1:0]  m00_axi_awburst,
  output logic                m00_axi_awlock,
  output logic [CACHE_W-1:0]  m00_axi_awcache,
  output logic [PROT_W-1:0]   m00_axi_awprot,
  output logic [QOS_W-1:0]    m00_axi_awqos,
  output logic                m00_axi_awvalid,
  input  logic                m00_axi_awready,
  output logic [DATA_W-1:0]   m00_axi_wdata,
  output logic [DATA_W/8-1:0] m00_axi_wstrb,
  output logic                m00_axi_wlast,
  output logic                m00_axi_wvalid,
  input  logic                m00_axi_wready,
  input  logic [ID_W-1:0]     m00_axi_bid,
  input  logic [1:0]          m00_axi_bresp,
  input  logic                m00_axi_bvalid,
  output logic                m00_axi_bready,
  output logic [ID_W-1:0]     m00_axi_arid,
  output logic [ADDR_W-1:0]   m00_axi_araddr,
  output logic [LEN_W-1:0]    m00_axi_arlen,
  output logic [SIZE_W-1:0]   m00_axi_arsize,
  output logic [BURST_W-1:0]  m00_axi_arburst,
  output logic                m00_axi_arlock,
  output logic [CACHE_W-1:0]  m00_axi_arcache,
  output logic [PROT_W-1:0]   m00_axi_arprot,
  output logic [QOS_W-1:0]    m00_axi_arqos,
  output logic                m00_axi_arvalid,
  input  logic                m00_axi_arready,
  input  logic [ID_W-1:0]     m00_axi_rid,
  input  logic [DATA_W-1:0]   m00_axi_rdata,
  input  logic [1:0]          m00_axi_rresp,
  input  logic                m00_axi_rlast,
  input  logic                m00_axi_rvalid,
  output logic                m00_axi_rready
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam int PAY_W = ID_W + ADDR_W + LEN_W + SIZE_W + BURST_W + 1
                       + CACHE_W + PROT_W + QOS_W;

  logic [ADDR_W-1:0] aw_addr_xlate;
  logic [ADDR_W-1:0] ar_addr_xlate;
  logic [PAY_W-1:0]  aw_pay_in;
  logic [PAY_W-1:0]  aw_pay_out;
  logic [PAY_W-1:0]  ar_pay_in;
  logic [PAY_W-1:0]  ar_pay_out;
  logic              aw_head_valid;
  logic              ar_head_valid;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              wr_room;
  logic              rd_room;
  logic              aw_issue;
  logic              ar_issue;
  logic              b_done;
  logic              r_done;

  assign aw_addr_xlate = ADDR_W'(translate_addr(XLATE_W'(s00_axi_awaddr),
                           COLOR_LSB, COLOR_MSB, BANK_LSB, BANK_W, ADDR_W));
  assign ar_addr_xlate = ADDR_W'(translate_addr(XLATE_W'(s00_axi_araddr),
                           COLOR_LSB, COLOR_MSB, BANK_LSB, BANK_W, ADDR_W));

  assign aw_pay_in = {s00_axi_awid, aw_addr_xlate, s00_axi_awlen, s00_axi_awsize,
                      s00_axi_awburst, s00_axi_awlock, s00_axi_awcache,
                      s00_axi_awprot, s00_axi_awqos};
  assign ar_pay_in = {s00_axi_arid, ar_addr_xlate, s00_axi_arlen, s00_axi_arsize,
                      s00_axi_arburst, s00_axi_arlock, s00_axi_arcache,
                      s00_axi_arprot, s00_axi_arqos};

  assign {m00_axi_awid, m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize,
          m00_axi_awburst, m00_axi_awlock, m00_axi_awcache,
          m00_axi_awprot, m00_axi_awqos} = aw_pay_out;
  assign {m00_axi_arid, m00_axi_araddr, m00_axi_arlen, m00_axi_arsize,
          m00_axi_arburst, m00_axi_arlock, m00_axi_arcache,
          m00_axi_arprot, m00_axi_arqos} = ar_pay_out;

  // Gating depends only on registered counters, so a raised valid cannot drop
  // before its handshake.
  assign wr_room         = (wr_cnt < CNT_MAX);
  assign rd_room         = (rd_cnt < CNT_MAX);
  assign m00_axi_awvalid = aw_head_valid & wr_room;
  assign m00_axi_arvalid = ar_head_valid & rd_room;
  assign aw_issue        = m00_axi_awvalid & m00_axi_awready;
  assign ar_issue        = m00_axi_arvalid & m00_axi_arready;
  assign b_done          = m00_axi_bvalid & s00_axi_bready;
  assign r_done          = m00_axi_rvalid & s00_axi_rready & m00_axi_rlast;

  axi_addr_skid #(.PAYLOAD_W(PAY_W)) u_aw_skid (
    .clk       (s00_axi_aclk),
    .reset     (s00_axi_areset),
    .s_valid   (s00_axi_awvalid),
    .s_ready   (s00_axi_awready),
    .s_payload (aw_pay_in),
    .m_valid   (aw_head_valid),
    .m_ready   (m00_axi_awready & wr_room),
    .m_payload (aw_pay_out)
  );

  axi_addr_skid #(.PAYLOAD_W(PAY_W)) u_ar_skid (
    .clk       (s00_axi_aclk),
    .reset     (s00_axi_areset),
    .s_valid   (s00_axi_arvalid),
    .s_ready   (s00_axi_arready),
    .s_payload (ar_pay_in),
    .m_valid   (ar_head_valid),
    .m_ready   (m00_axi_arready & rd_room),
    .m_payload (ar_pay_out)
  );

  // A response arriving with the counter at zero is a protocol violation; hold at zero.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (aw_issue && !b_done)                   wr_cnt <= wr_cnt + 1'b1;
      else if (b_done && !aw_issue && wr_cnt != '0) wr_cnt <= wr_cnt - 1'b1;
      if (ar_issue && !r_done)                   rd_cnt <= rd_cnt + 1'b1;
      else if (r_done && !ar_issue && rd_cnt != '0) rd_cnt <= rd_cnt - 1'b1;
    end
  end

  assign m00_axi_wdata  = s00_axi_wdata;
  assign m00_axi_wstrb  = s00_axi_wstrb;
  assign m00_axi_wlast  = s00_axi_wlast;
  assign m00_axi_wvalid = s00_axi_wvalid;
  assign s00_axi_wready = m00_axi_wready;
  assign s00_axi_bid    = m00_axi_bid;
  assign s00_axi_bresp  = m00_axi_bresp;
  assign s00_axi_bvalid = m00_axi_bvalid;
  assign m00_axi_bready = s00_axi_bready;
  assign s00_axi_rid    = m00_axi_rid;
  assign s00_axi_rdata  = m00_axi_rdata;
  assign s00_axi_rresp  = m00_axi_rresp;
  assign s00_axi_rlast  = m00_axi_rlast;
  assign s00_axi_rvalid = m00_axi_rvalid;
  assign m00_axi_rready = s00_axi_rready;

endmodule

// File: tb/tb_axi_color_translator.sv
// Directed bench for axi_color_translator: a queue-based transaction model
// checked every cycle, plus hand-computed literal expectations.
module tb_axi_color_translator;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // bench-driven inputs
  logic [15:0] s00_awid, s00_arid, m00_bid, m00_rid;
  logic [39:0] s00_awaddr, s00_araddr;
  logic [7:0] s00_awlen, s00_arlen;
  logic [2:0] s00_awsize, s00_arsize, s00_awprot, s00_arprot;
  logic [1:0] s00_awburst, s00_arburst, m00_bresp, m00_rresp;
  logic s00_awlock, s00_arlock, s00_awvalid, s00_arvalid;
  logic [3:0] s00_awcache, s00_arcache, s00_awqos, s00_arqos;
  logic [127:0] s00_wdata, m00_rdata;
  logic [15:0] s00_wstrb;
  logic s00_wlast, s00_wvalid, s00_bready, s00_rready;
  logic m00_awready, m00_wready, m00_bvalid, m00_arready, m00_rlast, m00_rvalid;

  // outputs of instance a (default colour layout) and b (alternate layout)
  logic a_s00_awready, a_s00_wready, a_s00_bvalid, a_s00_arready, a_s00_rlast, a_s00_rvalid;
  logic [15:0] a_s00_bid, a_s00_rid, a_m00_awid, a_m00_arid;
  logic [1:0] a_s00_bresp, a_s00_rresp, a_m00_awburst, a_m00_arburst;
  logic [127:0] a_s00_rdata, a_m00_wdata;
  logic [39:0] a_m00_awaddr, a_m00_araddr;
  logic [7:0] a_m00_awlen, a_m00_arlen;
  logic [2:0] a_m00_awsize, a_m00_arsize, a_m00_awprot, a_m00_arprot;
  logic a_m00_awlock, a_m00_arlock, a_m00_awvalid, a_m00_arvalid;
  logic [3:0] a_m00_awcache, a_m00_arcache, a_m00_awqos, a_m00_arqos;
  logic [15:0] a_m00_wstrb;
  logic a_m00_wlast, a_m00_wvalid, a_m00_bready, a_m00_rready;

  logic b_s00_awready, b_s00_wready, b_s00_bvalid, b_s00_arready, b_s00_rlast, b_s00_rvalid;
  logic [15:0] b_s00_bid, b_s00_rid, b_m00_awid, b_m00_arid;
  logic [1:0] b_s00_bresp, b_s00_rresp, b_m00_awburst, b_m00_arburst;
  logic [127:0] b_s00_rdata, b_m00_wdata;
  logic [39:0] b_m00_awaddr, b_m00_araddr;
  logic [7:0] b_m00_awlen, b_m00_arlen;
  logic [2:0] b_m00_awsize, b_m00_arsize, b_m00_awprot, b_m00_arprot;
  logic b_m00_awlock, b_m00_arlock, b_m00_awvalid, b_m00_arvalid;
  logic [3:0] b_m00_awcache, b_m00_arcache, b_m00_awqos, b_m00_arqos;
  logic [15:0] b_m00_wstrb;
  logic b_m00_wlast, b_m00_wvalid, b_m00_bready, b_m00_rready;

  axi_color_translator #(.MAX_OUTSTANDING(MAXO)) dut_a (
    .s00_axi_aclk(clk), .s00_axi_areset(reset),
    .s00_axi_awid(s00_awid), .s00_axi_awaddr(s00_awaddr), .s00_axi_awlen(s00_awlen),
    .s00_axi_awsize(s00_awsize), .s00_axi_awburst(s00_awburst), .s00_axi_awlock(s00_awlock),
    .s00_axi_awcache(s00_awcache), .s00_axi_awprot(s00_awprot), .s00_axi_awqos(s00_awqos),
    .s00_axi_awvalid(s00_awvalid), .s00_axi_awready(a_s00_awready),
    .s00_axi_wdata(s00_wdata), .s00_axi_wstrb(s00_wstrb), .s00_axi_wlast(s00_wlast),
    .s00_axi_wvalid(s00_wvalid), .s00_axi_wready(a_s00_wready),
    .s00_axi_bid(a_s00_bid), .s00_axi_bresp(a_s00_bresp), .s00_axi_bvalid(a_s00_bvalid),
    .s00_axi_bready(s00_bready),
    .s00_axi_arid(s00_arid), .s00_axi_araddr(s00_araddr), .s00_axi_arlen(s00_arlen),
    .s00_axi_arsize(s00_arsize), .s00_axi_arburst(s00_arburst), .s00_axi_arlock(s00_arlock),
    .s00_axi_arcache(s00_arcache), .s00_axi_arprot(s00_arprot), .s00_axi_arqos(s00_arqos),
    .s00_axi_arvalid(s00_arvalid), .s00_axi_arready(a_s00_arready),
    .s00_axi_rid(a_s00_rid), .s00_axi_rdata(a_s00_rdata), .s00_axi_rresp(a_s00_rresp),
    .s00_axi_rlast(a_s00_rlast), .s00_axi_rvalid(a_s00_rvalid), .s00_axi_rready(s00_rready),
    .m00_axi_awid(a_m00_awid), .m00_axi_awaddr(a_m00_awaddr), .m00_axi_awlen(a_m00_awlen),
    .m00_axi_awsize(a_m00_awsize), .m00_axi_awburst(a_m00_awburst), .m00_axi_awlock(a_m00_awlock),
    .m00_axi_awcache(a_m00_awcache), .m00_axi_awprot(a_m00_awprot), .m00_axi_awqos(a_m00_awqos),
    .m00_axi_awvalid(a_m00_awvalid), .m00_axi_awready(m00_awready),
    .m00_axi_wdata(a_m00_wdata), .m00_axi_wstrb(a_m00_wstrb), .m00_axi_wlast(a_m00_wlast),
    .m00_axi_wvalid(a_m00_wvalid), .m00_axi_wready(m00_wready),
    .m00_axi_bid(m00_bid), .m00_axi_bresp(m00_bresp), .m00_axi_bvalid(m00_bvalid),
    .m00_axi_bready(a_m00_bready),
    .m00_axi_arid(a_m00_arid), .m00_axi_araddr(a_m00_araddr), .m00_axi_arlen(a_m00_arlen),
    .m00_axi_arsize(a_m00_arsize), .m00_axi_arburst(a_m00_arburst), .m00_axi_arlock(a_m00_arlock),
    .m00_axi_arcache(a_m00_arcache), .m00_axi_arprot(a_m00_arprot), .m00_axi_arqos(a_m00_arqos),
    .m00_axi_arvalid(a_m00_arvalid), .m00_axi_arready(m00_arready),
    .m00_axi_rid(m00_rid), .m00_axi_rdata(m00_rdata), .m00_axi_rresp(m00_rresp),
    .m00_axi_rlast(m00_rlast), .m00_axi_rvalid(m00_rvalid), .m00_axi_rready(a_m00_rready)
  );

  axi_color_translator #(.COLOR_LSB(12), .COLOR_MSB(13), .BANK_LSB(32), .BANK_W(2),
                         .MAX_OUTSTANDING(MAXO)) dut_b (
    .s00_axi_aclk(clk), .s00_axi_areset(reset),
    .s00_axi_awid(s00_awid), .s00_axi_awaddr(s00_awaddr), .s00_axi_awlen(s00_awlen),
    .s00_axi_awsize(s00_awsize), .s00_axi_awburst(s00_awburst), .s00_axi_awlock(s00_awlock),
    .s00_axi_awcache(s00_awcache), .s00_axi_awprot(s00_awprot), .s00_axi_awqos(s00_awqos),
    .s00_axi_awvalid(s00_awvalid), .s00_axi_awready(b_s00_awready),
    .s00_axi_wdata(s00_wdata), .s00_axi_wstrb(s00_wstrb), .s00_axi_wlast(s00_wlast),
    .s00_axi_wvalid(s00_wvalid), .s00_axi_wready(b_s00_wready),
    .s00_axi_bid(b_s00_bid), .s00_axi_bresp(b_s00_bresp), .s00_axi_bvalid(b_s00_bvalid),
    .s00_axi_bready(s00_bready),
    .s00_axi_arid(s00_arid), .s00_axi_araddr(s00_araddr), .s00_axi_arlen(s00_arlen),
    .s00_axi_arsize(s00_arsize), .s00_axi_arburst(s00_arburst), .s00_axi_arlock(s00_arlock),
    .s00_axi_arcache(s00_arcache), .s00_axi_arprot(s00_arprot), .s00_axi_arqos(s00_arqos),
    .s00_axi_arvalid(s00_arvalid), .s00_axi_arready(b_s00_arready),
    .s00_axi_rid(b_s00_rid), .s00_axi_rdata(b_s00_rdata), .s00_axi_rresp(b_s00_rresp),
    .s00_axi_rlast(b_s00_rlast), .s00_axi_rvalid(b_s00_rvalid), .s00_axi_rready(s00_rready),
    .m00_axi_awid(b_m00_awid), .m00_axi_awaddr(b_m00_awaddr), .m00_axi_awlen(b_m00_awlen),
    .m00_axi_awsize(b_m00_awsize), .m00_axi_awburst(b_m00_awburst), .m00_axi_awlock(b_m00_awlock),
    .m00_axi_awcache(b_m00_awcache), .m00_axi_awprot(b_m00_awprot), .m00_axi_awqos(b_m00_awqos),
    .m00_axi_awvalid(b_m00_awvalid), .m00_axi_awready(m00_awready),
    .m00_axi_wdata(b_m00_wdata), .m00_axi_wstrb(b_m00_wstrb), .m00_axi_wlast(b_m00_wlast),
    .m00_axi_wvalid(b_m00_wvalid), .m00_axi_wready(m00_wready),
    .m00_axi_bid(m00_bid), .m00_axi_bresp(m00_bresp), .m00_axi_bvalid(m00_bvalid),
    .m00_axi_bready(b_m00_bready),
    .m00_axi_arid(b_m00_arid), .m00_axi_araddr(b_m00_araddr), .m00_axi_arlen(b_m00_arlen),
    .m00_axi_arsize(b_m00_arsize), .m00_axi_arburst(b_m00_arburst), .m00_axi_arlock(b_m00_arlock),
    .m00_axi_arcache(b_m00_arcache), .m00_axi_arprot(b_m00_arprot), .m00_axi_arqos(b_m00_arqos),
    .m00_axi_arvalid(b_m00_arvalid), .m00_axi_arready(m00_arready),
    .m00_axi_rid(m00_rid), .m00_axi_rdata(m00_rdata), .m00_axi_rresp(m00_rresp),
    .m00_axi_rlast(m00_rlast), .m00_axi_rvalid(m00_rvalid), .m00_axi_rready(b_m00_rready)
  );

  int tests = 0;
  int errors = 0;

  typedef struct {
    logic [80:0] pay_a;
    logic [39:0] addr_b;
  } entry_t;

  entry_t aw_q[$];
  entry_t ar_q[$];
  int wr_m = 0;
  int rd_m = 0;
  bit rst_prev = 1'b1;
  bit started = 1'b0;

  logic [80:0] a_aw_pay, a_ar_pay;
  assign a_aw_pay = {a_m00_awid, a_m00_awaddr, a_m00_awlen, a_m00_awsize, a_m00_awburst,
                     a_m00_awlock, a_m00_awcache, a_m00_awprot, a_m00_awqos};
  assign a_ar_pay = {a_m00_arid, a_m00_araddr, a_m00_arlen, a_m00_arsize, a_m00_arburst,
                     a_m00_arlock, a_m00_arcache, a_m00_arprot, a_m00_arqos};

  // Remove colour bits lsb..msb, slide the middle field down, keep the bank field.
  function automatic logic [39:0] model_xlate(input logic [39:0] a, input int lsb, input int msb,
                                              input int blsb, input int bw);
    logic [63:0] x, low, mid, bank;
    x    = 64'(a);
    low  = x % (64'd1 << lsb);
    mid  = (x >> (msb + 1)) % (64'd1 << (blsb - msb - 1));
    bank = (x >> blsb) % (64'd1 << bw);
    return 40'((bank << blsb) | (mid << lsb) | low);
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Per-cycle model comparison, then model update from this cycle's handshakes.
  always @(negedge clk) begin
    bit exp_awready, exp_awvalid, exp_arready, exp_arvalid, b_hs, r_last, m_aw, m_ar;
    entry_t e;
    exp_awready = !rst_prev && aw_q.size() < 2;
    exp_awvalid = !rst_prev && aw_q.size() > 0 && wr_m < MAXO;
    exp_arready = !rst_prev && ar_q.size() < 2;
    exp_arvalid = !rst_prev && ar_q.size() > 0 && rd_m < MAXO;
    if (started) begin
      checkOutput("awready", a_s00_awready, exp_awready);
      checkOutput("awvalid", a_m00_awvalid, exp_awvalid);
      checkOutput("arready", a_s00_arready, exp_arready);
      checkOutput("arvalid", a_m00_arvalid, exp_arvalid);
      if (exp_awvalid) begin
        checkOutput("aw_payload", a_aw_pay, aw_q[0].pay_a);
        checkOutput("aw_addr_alt", b_m00_awaddr, aw_q[0].addr_b);
      end
      if (exp_arvalid) begin
        checkOutput("ar_payload", a_ar_pay, ar_q[0].pay_a);
        checkOutput("ar_addr_alt", b_m00_araddr, ar_q[0].addr_b);
      end
      checkOutput("wr_cnt", dut_a.wr_cnt, wr_m);
      checkOutput("rd_cnt", dut_a.rd_cnt, rd_m);
      checkOutput("w_pass", {a_m00_wdata, a_m00_wstrb, a_m00_wlast, a_m00_wvalid, a_s00_wready},
                  {s00_wdata, s00_wstrb, s00_wlast, s00_wvalid, m00_wready});
      checkOutput("b_pass", {a_s00_bid, a_s00_bresp, a_s00_bvalid, a_m00_bready},
                  {m00_bid, m00_bresp, m00_bvalid, s00_bready});
      checkOutput("r_pass", {a_s00_rdata, a_s00_rid, a_s00_rresp, a_s00_rlast, a_s00_rvalid,
                  a_m00_rready}, {m00_rdata, m00_rid, m00_rresp, m00_rlast, m00_rvalid, s00_rready});
    end
    if (reset) begin
      aw_q.delete();
      ar_q.delete();
      wr_m = 0;
      rd_m = 0;
      rst_prev = 1'b1;
      started = 1'b1;
    end else if (started) begin
      m_aw   = exp_awvalid && m00_awready;
      m_ar   = exp_arvalid && m00_arready;
      b_hs   = m00_bvalid && s00_bready;
      r_last = m00_rvalid && s00_rready && m00_rlast;
      if (m_aw) void'(aw_q.pop_front());
      if (m_ar) void'(ar_q.pop_front());
      if (s00_awvalid && exp_awready) begin
        e.pay_a  = {s00_awid, model_xlate(s00_awaddr, 14, 15, 35, 1), s00_awlen, s00_awsize,
                    s00_awburst, s00_awlock, s00_awcache, s00_awprot, s00_awqos};
        e.addr_b = model_xlate(s00_awaddr, 12, 13, 32, 2);
        aw_q.push_back(e);
      end
      if (s00_arvalid && exp_arready) begin
        e.pay_a  = {s00_arid, model_xlate(s00_araddr, 14, 15, 35, 1), s00_arlen, s00_arsize,
                    s00_arburst, s00_arlock, s00_arcache, s00_arprot, s00_arqos};
        e.addr_b = model_xlate(s00_araddr, 12, 13, 32, 2);
        ar_q.push_back(e);
      end
      if (m_aw && !b_hs) wr_m++;
      else if (b_hs && !m_aw && wr_m > 0) wr_m--;
      if (m_ar && !r_last) rd_m++;
      else if (r_last && !m_ar && rd_m > 0) rd_m--;
      rst_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s00_wdata  = {$urandom, $urandom, $urandom, $urandom};
    s00_wstrb  = 16'($urandom);
    s00_wlast  = 1'($urandom);
    s00_wvalid = 1'($urandom);
    m00_wready = 1'($urandom);
    m00_rdata  = {$urandom, $urandom, $urandom, $urandom};
    m00_rid    = 16'($urandom);
    m00_rresp  = 2'($urandom);
    m00_bid    = 16'($urandom);
    m00_bresp  = 2'($urandom);
  endtask

  task automatic sendAw(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len);
    int n = 0;
    s00_awid = id; s00_awaddr = addr; s00_awlen = len; s00_awsize = 3'(id);
    s00_awburst = 2'(id + 1); s00_awlock = id[0]; s00_awcache = 4'(id + 3);
    s00_awprot = 3'(id + 2); s00_awqos = 4'(id + 5); s00_awvalid = 1'b1;
    while (!a_s00_awready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      tests++; errors++;
      $display("[TB] FAIL aw_accept_timeout: actual no awready required awready within 50 cycles");
    end
    tick();
  endtask

  task automatic sendAr(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len);
    int n = 0;
    s00_arid = id; s00_araddr = addr; s00_arlen = len; s00_arsize = 3'(id + 1);
    s00_arburst = 2'(id); s00_arlock = id[1]; s00_arcache = 4'(id + 7);
    s00_arprot = 3'(id); s00_arqos = 4'(id + 9); s00_arvalid = 1'b1;
    while (!a_s00_arready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      tests++; errors++;
      $display("[TB] FAIL ar_accept_timeout: actual no arready required arready within 50 cycles");
    end
    tick();
  endtask

  task automatic applyStimulus();
    reset = 1'b1;
    s00_awid = '0; s00_awaddr = '0; s00_awlen = '0; s00_awsize = '0; s00_awburst = '0;
    s00_awlock = 1'b0; s00_awcache = '0; s00_awprot = '0; s00_awqos = '0; s00_awvalid = 1'b0;
    s00_arid = '0; s00_araddr = '0; s00_arlen = '0; s00_arsize = '0; s00_arburst = '0;
    s00_arlock = 1'b0; s00_arcache = '0; s00_arprot = '0; s00_arqos = '0; s00_arvalid = 1'b0;
    s00_bready = 1'b1; s00_rready = 1'b1;
    m00_awready = 1'b1; m00_arready = 1'b1; m00_bvalid = 1'b0; m00_rvalid = 1'b0; m00_rlast = 1'b0;
    repeat (3) tick();
    checkOutput("rst_awready", a_s00_awready, 1'b0);
    checkOutput("rst_arready", a_s00_arready, 1'b0);
    checkOutput("rst_awvalid", a_m00_awvalid, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("release_awready", a_s00_awready, 1'b1);
    checkOutput("release_arready", a_s00_arready, 1'b1);

    // basic translation, one-cycle latency
    sendAw(16'd1, 40'h8_0000_C123, 8'd0);
    s00_awvalid = 1'b0;
    checkOutput("aw_latency", a_m00_awvalid, 1'b1);
    checkOutput("aw_xlate_lit", a_m00_awaddr, 40'h8_0000_0123);
    tick();
    m00_bvalid = 1'b1; tick(); m00_bvalid = 1'b0;
    sendAr(16'd2, 40'h0_0001_4005, 8'd0);
    s00_arvalid = 1'b0;
    checkOutput("ar_xlate_lit", a_m00_araddr, 40'h0_0000_4005);
    tick();
    m00_rvalid = 1'b1; m00_rlast = 1'b1; tick(); m00_rvalid = 1'b0; m00_rlast = 1'b0;
    sendAw(16'd3, 40'h3_0000_7ABC, 8'd0);
    s00_awvalid = 1'b0;
    checkOutput("alt_xlate_lit", b_m00_awaddr, 40'h3_0000_1ABC);
    tick();
    m00_bvalid = 1'b1; tick(); m00_bvalid = 1'b0;

    // back-to-back AWs into a stalled master
    fork
      begin
        for (int i = 0; i < 4; i++) sendAw(16'(10 + i), 40'h0_1234_0000 + 40'(i * 16'h5A5), 8'(i));
        s00_awvalid = 1'b0;
      end
      begin
        m00_awready = 1'b0;
        tick(); tick();
        checkOutput("full_awready", a_s00_awready, 1'b0);
        tick();
        m00_awready = 1'b1;
      end
    join
    repeat (4) tick();

    // outstanding limit: 4 in flight, two more queue up
    sendAw(16'd20, 40'h8_00AB_C000, 8'd1);
    sendAw(16'd21, 40'h0_00FF_FFFF, 8'd2);
    s00_awvalid = 1'b0;
    tick();
    checkOutput("limit_awvalid", a_m00_awvalid, 1'b0);
    m00_bvalid = 1'b1; tick(); m00_bvalid = 1'b0;
    checkOutput("limit_release", a_m00_awvalid, 1'b1);
    tick();
    m00_awready = 1'b0;
    m00_bvalid = 1'b1; tick(); m00_bvalid = 1'b0;
    sendAw(16'd22, 40'h0_0000_8001, 8'd0);
    s00_awvalid = 1'b0;

    // reset mid-traffic: two buffered, three outstanding
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_awvalid", a_m00_awvalid, 1'b0);
    checkOutput("rst_mid_wr_cnt", dut_a.wr_cnt, 0);
    tick();
    reset = 1'b0;
    m00_awready = 1'b1;
    tick();
    sendAw(16'd30, 40'h8_0003_FFFF, 8'd0);
    s00_awvalid = 1'b0;
    checkOutput("post_rst_latency", a_m00_awvalid, 1'b1);
    tick();
    m00_bvalid = 1'b1; tick(); tick(); m00_bvalid = 1'b0;

    // read burst counting only on rlast
    sendAr(16'd40, 40'h0_0002_C010, 8'd3);
    s00_arvalid = 1'b0;
    tick();
    m00_rvalid = 1'b1;
    tick(); tick(); tick();
    checkOutput("rd_mid_burst", dut_a.rd_cnt, 1);
    m00_rlast = 1'b1; tick(); m00_rvalid = 1'b0; m00_rlast = 1'b0;
    checkOutput("rd_after_last", dut_a.rd_cnt, 0);
    sendAr(16'd41, 40'h8_0000_4000, 8'd0);
    s00_arvalid = 1'b0;
    tick();
    m00_arready = 1'b0;
    sendAr(16'd42, 40'h0_0000_C0DE, 8'd0);
    s00_arvalid = 1'b0;
    m00_arready = 1'b1; m00_rvalid = 1'b1; m00_rlast = 1'b1;
    tick();
    m00_rvalid = 1'b0; m00_rlast = 1'b0;
    checkOutput("rd_coincide", dut_a.rd_cnt, 1);
    m00_rvalid = 1'b1; m00_rlast = 1'b1; tick(); m00_rvalid = 1'b0; m00_rlast = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_color_translator.md
# axi_color_translator

Parametrised AXI4 address translator between the coloured-address slave port and the memory-side master port. It removes a configurable contiguous colour-bit field and compacts the address bits above it. A configurable bank field is kept in place. Registered two-entry skid buffers sit on AW and AR, and per-direction outstanding-transaction counters cap in-flight bursts. W, B and R beats pass straight through.

## Interface
Parameters:
- COLOR_LSB, 14, lowest colour bit removed.
- COLOR_MSB, 15, highest colour bit removed; COLOR_W = COLOR_MSB-COLOR_LSB+1.
- BANK_LSB, 35, lowest bank bit kept at its original position; must exceed COLOR_MSB.
- BANK_W, 1, bank field width; BANK_LSB+BANK_W ≤ ADDR_W.
- MAX_OUTSTANDING, 8, in-flight limit per direction (1..255).
- ID_W, 16, AXI ID width.
- ADDR_W, 40, address width.
- DATA_W, 128, data width.

Ports:
- s00_axi_aclk  in  1  single clock for both ports.
- s00_axi_areset  in  1  reset, synchronous, active-high.
- s00_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos}  in  AXI4 widths  write address from upstream.
- s00_axi_awvalid in 1, s00_axi_awready out 1.
- s00_axi_w{data,strb,last,valid} in, s00_axi_wready out  write data.
- s00_axi_b{id,resp,valid} out, s00_axi_bready in  write response.
- s00_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos}, s00_axi_arvalid in, s00_axi_arready out  read address.
- s00_axi_r{id,data,resp,last,valid} out, s00_axi_rready in  read data.
- m00_axi_*: the mirror set of all of the above, opposite directions, same widths.

## Operation
- Translation, identical for AW and AR, applied on slave-side capture:
  - out[BANK_LSB+BANK_W-1:BANK_LSB] = in[same bits].
  - out[BANK_LSB-COLOR_W-1:COLOR_LSB] = in[BANK_LSB-1:COLOR_MSB+1].
  - out[COLOR_LSB-1:0] = in[COLOR_LSB-1:0].
  - out[BANK_LSB-1:BANK_LSB-COLOR_W] = 0.
  - All bits above the bank field are 0.
- AW and AR skid buffers:
  - 2 entries each, FIFO order.
  - Each entry stores the translated address plus all other attributes unchanged.
  - s_ready = (occupancy < 2), registered.
- Outstanding write counter wr_cnt:
  - +1 on an m00 AW handshake; -1 on an s00 B handshake (bvalid & bready).
  - Simultaneous +1 and -1 leaves it unchanged.
- Outstanding read counter rd_cnt:
  - +1 on an m00 AR handshake; -1 only on an R handshake with rlast=1.
- Counter width is clog2(MAX_OUTSTANDING+1). Counters never wrap.
- Issue gating:
  - m00_axi_awvalid = aw_head_valid & (wr_cnt < MAX_OUTSTANDING).
  - m00_axi_arvalid likewise with rd_cnt.
  - Once asserted, a valid holds until handshake, since a counter can only rise through its own handshake.
- W, B, R: pure combinational pass-through. W may precede AW; no reordering, no ID remapping.
- Decrement with counter already 0 (protocol violation): counter holds at 0.

## Timing
- AW/AR latency: slave handshake in cycle N makes m00 valid in N+1 if the limit permits. Throughput is 1 per cycle when downstream is ready.
- No combinational path from any s00 input to m00_aw*/m00_ar* or to s00 awready/arready.
- Full buffer with m00 ready in the same cycle: pop happens, push is refused (s_ready was already 0). s_ready rises the next cycle.
- Reset, any cycle, including mid-burst:
  - The next edge empties both buffers and clears both counters.
  - m00_axi_awvalid, m00_axi_arvalid, s00_axi_awready and s00_axi_arready are 0 while reset is asserted.
  - The ready signals go to 1 on the first cycle after release.
  - Pass-through outputs follow their inputs during reset.

## Structure
- Package axi_color_pkg holds:
  - The translate_addr function, parametrised on COLOR_LSB, COLOR_MSB, BANK_LSB, BANK_W and ADDR_W.
  - The AXI attribute bundle widths (len 8, size 3, burst 2, cache 4, prot 3, qos 4).
  - The outstanding counter-width helper.
- Sub-module axi_addr_skid is the generic 2-entry register slice on a packed payload. It is instantiated for AW and AR.
- The top holds translation, counters, gating and pass-through wiring.

## Test plan
- Default params, awaddr 40'h8_0000_C123 -> m00_axi_awaddr 40'h8_0000_0123 one cycle later; araddr 40'h0_0001_4005 -> m00_axi_araddr 40'h0_0000_4005.
- m00 awready low for 3 cycles, 4 back-to-back AWs -> s00 awready drops after 2 accepted; all 4 emerge in order with attributes intact.
- MAX_OUTSTANDING=4, bvalid held low, 6 AWs -> exactly 4 m00 AW handshakes and m00 awvalid then low. One B handshake -> 5th AW issues next cycle.
- Read burst arlen=3 with rd_cnt=1 -> rd_cnt stays 1 through beats 1-3 and reaches 0 only after the rlast beat. An AR handshake coinciding with the rlast beat leaves rd_cnt at 1.
- Reset asserted with 2 AW entries buffered and wr_cnt=3 -> next cycle m00 awvalid=0, wr_cnt=0. After release, a new AW passes with 1-cycle latency.
- COLOR_LSB=12, COLOR_MSB=13, BANK_LSB=32, BANK_W=2, addr 40'h3_0000_7ABC -> 40'h3_0000_1ABC.
